// File: rtl/butterfly_pair_serializer_pkg.sv
// Shared constants for the FFT butterfly pair serializer: widths, beat codes
// and FSM state encodings.
package butterfly_pair_serializer_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_N_POINTS   = 32;

  localparam logic [1:0] BEAT_A_RE = 2'd0;
  localparam logic [1:0] BEAT_B_RE = 2'd1;
  localparam logic [1:0] BEAT_A_IM = 2'd2;
  localparam logic [1:0] BEAT_B_IM = 2'd3;

  localparam logic [1:0] ST_LOAD_A = 2'd0;
  localparam logic [1:0] ST_LOAD_B = 2'd1;
  localparam logic [1:0] ST_EMIT   = 2'd2;

  function automatic int pairs_of(input int n_points);
    return n_points / 2;
  endfunction

endpackage

// File: rtl/butterfly_pair_serializer_if.sv
// Sample-in / word-out handshake bundle of the butterfly pair serializer.
interface butterfly_pair_serializer_if
  import butterfly_pair_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int N_POINTS   = DEFAULT_N_POINTS
) ();

  localparam int PAIRS = pairs_of(N_POINTS);
  localparam int IDX_W = $clog2(PAIRS);

  logic                  flush;
  logic [DATA_WIDTH-1:0] in_real;
  logic [DATA_WIDTH-1:0] in_imag;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out_word;
  logic [1:0]            out_beat;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;
  logic [IDX_W-1:0]      pair_idx;

  modport master (
    output flush, in_real, in_imag, in_valid, out_ready,
    input  in_ready, out_word, out_beat, out_valid, out_last, pair_idx
  );

  modport slave (
    input  flush, in_real, in_imag, in_valid, out_ready,
    output in_ready, out_word, out_beat, out_valid, out_last, pair_idx
  );

endinterface

// File: rtl/butterfly_pair_serializer_pair_word_mux.sv
// 4:1 word select feeding the serialized output, indexed by the beat code.
module butterfly_pair_serializer_pair_word_mux
  import butterfly_pair_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] a_re,
  input  logic [DATA_WIDTH-1:0] b_re,
  input  logic [DATA_WIDTH-1:0] a_im,
  input  logic [DATA_WIDTH-1:0] b_im,
  input  logic [1:0]            beat,
  output logic [DATA_WIDTH-1:0] word
);

  always_comb begin
    word = a_re;
    case (beat)
      BEAT_B_RE: word = b_re;
      BEAT_A_IM: word = a_im;
      BEAT_B_IM: word = b_im;
      default:   word = a_re;
    endcase
  end

endmodule

// File: rtl/butterfly_pair_serializer.sv
// Pairs consecutive complex samples and emits each pair as A_re, B_re, A_im,
// B_im with a beat code, pair index and end-of-frame flag.
module butterfly_pair_serializer
  import butterfly_pair_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int N_POINTS   = DEFAULT_N_POINTS
) (
  input logic                        clk,
  input logic                        rst,
  butterfly_pair_serializer_if.slave bus
);

  localparam int PAIRS = pairs_of(N_POINTS);
  localparam int IDX_W = $clog2(PAIRS);
  localparam logic [IDX_W-1:0] LAST_PAIR = IDX_W'(PAIRS - 1);

  logic [1:0]            state_reg, state_next;
  logic [1:0]            beat_reg, beat_next;
  logic [IDX_W-1:0]      pair_reg, pair_next;
  logic [DATA_WIDTH-1:0] a_re_reg, a_re_next, a_im_reg, a_im_next;
  logic [DATA_WIDTH-1:0] b_re_reg, b_re_next, b_im_reg, b_im_next;
  logic                  in_ready_reg, out_valid_reg, out_last_reg;
  logic                  in_fire, out_fire;

  assign in_fire  = bus.in_valid && in_ready_reg;
  assign out_fire = out_valid_reg && bus.out_ready;

  always_comb begin
    state_next = state_reg;
    beat_next  = beat_reg;
    pair_next  = pair_reg;
    a_re_next  = a_re_reg;
    a_im_next  = a_im_reg;
    b_re_next  = b_re_reg;
    b_im_next  = b_im_reg;
    case (state_reg)
      ST_LOAD_A: if (in_fire) begin
        a_re_next  = bus.in_real;
        a_im_next  = bus.in_imag;
        state_next = ST_LOAD_B;
      end
      ST_LOAD_B: if (in_fire) begin
        b_re_next  = bus.in_real;
        b_im_next  = bus.in_imag;
        beat_next  = BEAT_A_RE;
        state_next = ST_EMIT;
      end
      ST_EMIT: if (out_fire) begin
        if (beat_reg == BEAT_B_IM) begin
          beat_next  = BEAT_A_RE;
          pair_next  = (pair_reg == LAST_PAIR) ? '0 : pair_reg + IDX_W'(1);
          state_next = ST_LOAD_A;
        end else begin
          beat_next = beat_reg + 2'd1;
        end
      end
      default: state_next = ST_LOAD_A;
    endcase
    // Flush wins over both handshakes; the held A/B are left as they were.
    if (bus.flush) begin
      state_next = ST_LOAD_A;
      beat_next  = BEAT_A_RE;
      pair_next  = '0;
      a_re_next  = a_re_reg;
      a_im_next  = a_im_reg;
      b_re_next  = b_re_reg;
      b_im_next  = b_im_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_LOAD_A;
      beat_reg      <= BEAT_A_RE;
      pair_reg      <= '0;
      a_re_reg      <= '0;
      a_im_reg      <= '0;
      b_re_reg      <= '0;
      b_im_reg      <= '0;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      beat_reg      <= beat_next;
      pair_reg      <= pair_next;
      a_re_reg      <= a_re_next;
      a_im_reg      <= a_im_next;
      b_re_reg      <= b_re_next;
      b_im_reg      <= b_im_next;
      // Handshake flags are precomputed from the next state so they are
      // registered yet aligned with the state they describe.
      in_ready_reg  <= (state_next != ST_EMIT);
      out_valid_reg <= (state_next == ST_EMIT);
      out_last_reg  <= (state_next == ST_EMIT) && (beat_next == BEAT_B_IM)
                       && (pair_next == LAST_PAIR);
    end
  end

  butterfly_pair_serializer_pair_word_mux #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_word_mux (
    .a_re (a_re_reg),
    .b_re (b_re_reg),
    .a_im (a_im_reg),
    .b_im (b_im_reg),
    .beat (beat_reg),
    .word (bus.out_word)
  );

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_beat  = beat_reg;
  assign bus.out_last  = out_last_reg;
  assign bus.pair_idx  = pair_reg;

endmodule

// File: tb/tb_butterfly_pair_serializer.sv
// Scenario bench for butterfly_pair_serializer with a queue-based pair model.
module tb_butterfly_pair_serializer;

  localparam int DW    = 32;
  localparam int NP    = 32;
  localparam int PAIRS = NP / 2;
  localparam int IW    = $clog2(PAIRS);

  typedef struct packed {
    logic [DW-1:0] word;
    logic [1:0]    beat;
    logic          last;
    logic [IW-1:0] pidx;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  butterfly_pair_serializer_if #(.DATA_WIDTH(DW), .N_POINTS(NP)) bus ();

  butterfly_pair_serializer #(.DATA_WIDTH(DW), .N_POINTS(NP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: samples pair up in arrival order; every completed pair
  // yields A_re, B_re, A_im, B_im tagged with its frame-relative pair index.
  exp_t          exp_q[$];
  logic [DW-1:0] src_re[$], src_im[$];
  logic [DW-1:0] a_re_m, a_im_m;
  bit            have_a;
  int            pair_count;

  function automatic void model_in(input logic [DW-1:0] re, input logic [DW-1:0] im);
    logic [IW-1:0] p;
    if (!have_a) begin
      a_re_m = re; a_im_m = im; have_a = 1'b1;
    end else begin
      p = IW'(pair_count % PAIRS);
      exp_q.push_back('{a_re_m, 2'd0, 1'b0, p});
      exp_q.push_back('{re,     2'd1, 1'b0, p});
      exp_q.push_back('{a_im_m, 2'd2, 1'b0, p});
      exp_q.push_back('{im,     2'd3, (p == IW'(PAIRS - 1)), p});
      pair_count++;
      have_a = 1'b0;
    end
  endfunction

  function automatic void model_clear();
    have_a = 1'b0;
    pair_count = 0;
    exp_q.delete();
  endfunction

  bit   in_fire, out_fire;
  exp_t obs, e;

  // Drives one cycle's inputs at the falling edge and records what will
  // transfer on the following rising edge.
  task automatic tick(input bit ordy, input bit fl, input bit feed);
    @(negedge clk);
    bus.out_ready = ordy;
    bus.flush     = fl;
    bus.in_valid  = feed && (src_re.size() > 0);
    if (src_re.size() > 0) begin
      bus.in_real = src_re[0];
      bus.in_imag = src_im[0];
    end
    in_fire  = !fl && bus.in_valid && bus.in_ready;
    out_fire = !fl && bus.out_valid && bus.out_ready;
    obs = '{bus.out_word, bus.out_beat, bus.out_last, bus.pair_idx};
    if (in_fire) begin
      $display("t=%0t in  re=%h im=%h", $time, src_re[0], src_im[0]);
      model_in(src_re.pop_front(), src_im.pop_front());
    end
    if (out_fire)
      $display("t=%0t out word=%h beat=%0d pidx=%0d last=%0b", $time, obs.word, obs.beat, obs.pidx, obs.last);
    if (fl) model_clear();
  endtask

  task automatic push_random(input int n);
    for (int i = 0; i < n; i++) begin
      src_re.push_back($urandom());
      src_im.push_back($urandom());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.in_real = '0; bus.in_imag = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.out_word !== '0) begin n_bad++; $display("FAIL reset_out_word got %h want 0", bus.out_word); end
    n_cmp++; if ({bus.out_beat, bus.out_last, bus.pair_idx} !== '0)
      begin n_bad++; $display("FAIL reset_beat_last_pidx got %0d/%b/%0d want 0/0/0", bus.out_beat, bus.out_last, bus.pair_idx); end
    rst = 1'b0;
    model_clear();
    @(negedge clk);
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL post_reset_in_ready got %b want 1", bus.in_ready); end
  endtask

  task automatic test_basic();
    int valid_cycles = 0, first_valid = -1, b_cyc = -1, words = 0;
    src_re.push_back(32'd1); src_im.push_back(32'd2);
    src_re.push_back(32'd3); src_im.push_back(32'd4);
    for (int cyc = 0; cyc < 20 && words < 4; cyc++) begin
      tick(1'b1, 1'b0, 1'b1);
      if (in_fire && src_re.size() == 0) b_cyc = cyc;
      if (bus.out_valid) begin
        valid_cycles++;
        if (first_valid < 0) first_valid = cyc;
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL basic_in_ready_emit got %b want 0", bus.in_ready); end
      end
      if (out_fire) begin
        words++; n_cmp++;
        if (exp_q.size() == 0) begin n_bad++; $display("FAIL basic_word unexpected word %h", obs.word); end
        else begin
          e = exp_q.pop_front();
          if (obs !== e) begin n_bad++; $display("FAIL basic_word got %h/%0d/%b/%0d want %h/%0d/%b/%0d", obs.word, obs.beat, obs.last, obs.pidx, e.word, e.beat, e.last, e.pidx); end
        end
      end
    end
    n_cmp++; if (valid_cycles != 4) begin n_bad++; $display("FAIL basic_valid_cycles got %0d want 4", valid_cycles); end
    n_cmp++; if (first_valid != b_cyc + 1 || b_cyc < 0) begin n_bad++; $display("FAIL basic_latency got %0d want %0d", first_valid, b_cyc + 1); end
    tick(1'b0, 1'b0, 1'b0);
    n_cmp++; if ({bus.out_valid, bus.in_ready} !== 2'b01) begin n_bad++; $display("FAIL basic_after valid/ready got %b%b want 01", bus.out_valid, bus.in_ready); end
  endtask

  task automatic test_stall();
    logic [DW-1:0] bre;
    bit got0 = 1'b0;
    int words = 0;
    push_random(2);
    bre = src_re[1];
    for (int cyc = 0; cyc < 20 && !got0; cyc++) begin
      tick(1'b1, 1'b0, 1'b1);
      if (out_fire) begin
        n_cmp++; e = exp_q.pop_front();
        if (obs !== e) begin n_bad++; $display("FAIL stall_pre_word got %h/%0d want %h/%0d", obs.word, obs.beat, e.word, e.beat); end
        got0 = (obs.beat == 2'd0);
      end
    end
    for (int s = 0; s < 5; s++) begin
      tick(1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (bus.out_valid !== 1'b1 || obs.word !== bre || obs.beat !== 2'd1)
        begin n_bad++; $display("FAIL stall_hold valid=%b word=%h beat=%0d want 1/%h/1", bus.out_valid, obs.word, obs.beat, bre); end
    end
    for (int cyc = 0; cyc < 20 && exp_q.size() > 0; cyc++) begin
      tick(1'b1, 1'b0, 1'b0);
      if (out_fire) begin
        words++; n_cmp++; e = exp_q.pop_front();
        if (obs !== e) begin n_bad++; $display("FAIL stall_resume got %h/%0d want %h/%0d", obs.word, obs.beat, e.word, e.beat); end
      end
    end
    n_cmp++; if (words != 3) begin n_bad++; $display("FAIL stall_resume_count got %0d want 3", words); end
  endtask

  task automatic test_flush();
    bit got1 = 1'b0;
    int words = 0;
    push_random(2);
    for (int cyc = 0; cyc < 20 && !got1; cyc++) begin
      tick(1'b1, 1'b0, 1'b1);
      if (out_fire) begin
        n_cmp++; e = exp_q.pop_front();
        if (obs !== e) begin n_bad++; $display("FAIL flush_pre_word got %h/%0d want %h/%0d", obs.word, obs.beat, e.word, e.beat); end
        got1 = (obs.beat == 2'd1);
      end
    end
    tick(1'b1, 1'b1, 1'b0);
    n_cmp++; if (bus.out_valid !== 1'b1 || obs.beat !== 2'd2) begin n_bad++; $display("FAIL flush_at_beat2 valid=%b beat=%0d want 1/2", bus.out_valid, obs.beat); end
    tick(1'b0, 1'b0, 1'b0);
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_out_valid got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.out_beat !== 2'd0 || bus.pair_idx !== '0) begin n_bad++; $display("FAIL flush_beat_pidx got %0d/%0d want 0/0", bus.out_beat, bus.pair_idx); end
    push_random(2);
    for (int cyc = 0; cyc < 20 && words < 4; cyc++) begin
      tick(1'b1, 1'b0, 1'b1);
      if (out_fire) begin
        words++; n_cmp++; e = exp_q.pop_front();
        if (obs !== e) begin n_bad++; $display("FAIL flush_restart got %h/%0d/%0d want %h/%0d/%0d", obs.word, obs.beat, obs.pidx, e.word, e.beat, e.pidx); end
      end
    end
    n_cmp++; if (words != 4) begin n_bad++; $display("FAIL flush_restart_count got %0d want 4", words); end
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    n_cmp++; if (bus.pair_idx !== '0) begin n_bad++; $display("FAIL idle_flush_pidx got %0d want 0", bus.pair_idx); end
  endtask

  task automatic test_frame();
    int words = 0, last_pos = -1, first_in = -1, last_out = -1;
    for (int k = 0; k < NP; k++) begin
      src_re.push_back(DW'(k)); src_im.push_back(DW'(k));
    end
    for (int cyc = 0; cyc < 300 && words < 2 * NP; cyc++) begin
      tick(1'b1, 1'b0, 1'b1);
      if (in_fire && first_in < 0) first_in = cyc;
      if (out_fire) begin
        words++; last_out = cyc; n_cmp++;
        if (obs.last) last_pos = words;
        if (exp_q.size() == 0) begin n_bad++; $display("FAIL frame_word unexpected %h", obs.word); end
        else begin
          e = exp_q.pop_front();
          if (obs !== e) begin n_bad++; $display("FAIL frame_word #%0d got %h/%0d/%b/%0d want %h/%0d/%b/%0d", words, obs.word, obs.beat, obs.last, obs.pidx, e.word, e.beat, e.last, e.pidx); end
        end
      end
    end
    n_cmp++; if (words != 2 * NP) begin n_bad++; $display("FAIL frame_count got %0d want %0d", words, 2 * NP); end
    n_cmp++; if (last_pos != 2 * NP) begin n_bad++; $display("FAIL frame_last_pos got %0d want %0d", last_pos, 2 * NP); end
    n_cmp++; if (last_out - first_in + 1 != 6 * PAIRS) begin n_bad++; $display("FAIL frame_throughput got %0d cycles want %0d", last_out - first_in + 1, 6 * PAIRS); end
    tick(1'b0, 1'b0, 1'b0);
    n_cmp++; if (bus.pair_idx !== '0) begin n_bad++; $display("FAIL frame_pidx_wrap got %0d want 0", bus.pair_idx); end
  endtask

  task automatic test_async_reset();
    bit got0 = 1'b0, got_a = 1'b0;
    int words = 0;
    push_random(2);
    for (int cyc = 0; cyc < 20 && !got0; cyc++) begin
      tick(1'b1, 1'b0, 1'b1);
      if (out_fire) begin
        n_cmp++; e = exp_q.pop_front();
        if (obs !== e) begin n_bad++; $display("FAIL arst_pre_word got %h want %h", obs.word, e.word); end
        got0 = 1'b1;
      end
    end
    tick(1'b0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({bus.out_valid, bus.out_last, bus.in_ready} !== 3'b000) begin n_bad++; $display("FAIL arst_emit valid/last/ready got %b%b%b want 000", bus.out_valid, bus.out_last, bus.in_ready); end
    n_cmp++; if (bus.out_beat !== 2'd0 || bus.pair_idx !== '0) begin n_bad++; $display("FAIL arst_emit beat/pidx got %0d/%0d want 0/0", bus.out_beat, bus.pair_idx); end
    model_clear();
    @(negedge clk) rst = 1'b0;
    push_random(1);
    for (int cyc = 0; cyc < 10 && !got_a; cyc++) begin
      tick(1'b1, 1'b0, 1'b1);
      got_a = in_fire;
    end
    n_cmp++; if (!got_a) begin n_bad++; $display("FAIL arst_load_a accepted=0 want 1"); end
    tick(1'b0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL arst_load_b in_ready got %b want 0", bus.in_ready); end
    model_clear();
    @(negedge clk) rst = 1'b0;
    push_random(2);
    for (int cyc = 0; cyc < 20 && words < 4; cyc++) begin
      tick(1'b1, 1'b0, 1'b1);
      if (out_fire) begin
        words++; n_cmp++; e = exp_q.pop_front();
        if (obs !== e) begin n_bad++; $display("FAIL arst_after got %h/%0d want %h/%0d", obs.word, obs.beat, e.word, e.beat); end
      end
    end
    n_cmp++; if (words != 4) begin n_bad++; $display("FAIL arst_after_count got %0d want 4", words); end
  endtask

  task automatic test_back_to_back();
    int accepts = 0, words = 0;
    push_random(16);
    for (int cyc = 0; cyc < 400 && (exp_q.size() > 0 || src_re.size() > 0); cyc++) begin
      tick(1'($urandom_range(0, 1)), 1'b0, 1'b1);
      n_cmp++; if (bus.in_ready && bus.out_valid) begin n_bad++; $display("FAIL b2b_ready_in_emit ready=1 valid=1 want not both"); end
      if (in_fire) accepts++;
      if (out_fire) begin
        words++; n_cmp++;
        if (exp_q.size() == 0) begin n_bad++; $display("FAIL b2b_word unexpected %h", obs.word); end
        else begin
          e = exp_q.pop_front();
          if (obs !== e) begin n_bad++; $display("FAIL b2b_word got %h/%0d/%0d want %h/%0d/%0d", obs.word, obs.beat, obs.pidx, e.word, e.beat, e.pidx); end
        end
      end
    end
    n_cmp++; if (accepts != 16 || words != 32) begin n_bad++; $display("FAIL b2b_counts accepts=%0d words=%0d want 16/32", accepts, words); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_flush();
    test_frame();
    test_async_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
